pitch_const_div: RTL and testbench
==================================

# pitch_const_div

Pitch-arithmetic helper for the synth engine's per-voice/per-oscillator pitch path. It combines two independent pipelined channels. The first is a key-to-phase-increment constant map: a 9-bit offset key index in, a 24-bit increment out. The second is an unsigned 24÷8 divider used for the modulator:carrier ratio. It runs on the oscillator-slot clock, so a new key and a new division are accepted every cycle.

## Interface
- `REF_KEY`, default 197: key index mapping exactly to `REF_VAL` (MIDI note 69 + 128 offset).
- `REF_VAL`, default 24'h258BF2: increment for `REF_KEY` (440 Hz, 48 kHz, 28-bit accumulator).
- `sCLK_XVXOSC`, input, 1: the single clock, rising edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `sound`, input, 9: key index, MIDI note + 128 (unsigned 0..511).
- `constant`, output, 24: phase increment for `sound`, registered.
- `numer`, input, 24: unsigned dividend.
- `denom`, input, 8: unsigned divisor.
- `quotient`, output, 25: unsigned quotient, zero-extended (bit 24 always 0), registered.

## Operation
- No handshake. Both channels sample their inputs on every rising edge and are fully independent.
- Constant map:
  - d = sound − REF_KEY (signed).
  - o = floor(d/12); k = d − 12·o, range 0..11.
  - T[k] = round(REF_VAL · 2^(k/12) · 256): a 12-entry constant table, 32-bit.
  - v = T[k] · 2^o / 256, truncated toward zero. Implement as a shift left by o−8 if o ≥ 8, else a shift right by 8−o. Shifts ≥ 32 yield 0 (right) or saturate (left).
  - constant = v if v ≤ 24'hFFFFFF, else 24'hFFFFFF (see Configuration).
  - d = 0 gives REF_VAL exactly. d = ±12·n gives REF_VAL·2^n before saturation or truncation.
- Divider:
  - quotient = floor(numer/denom), with 24-bit unsigned arithmetic.
  - denom = 0 gives quotient = 25'h0FFFFFF; no other flag.
  - denom = 1 gives quotient = numer.
- Arithmetic is unsigned throughout. The output registers are the only state.

## Timing
- `constant`: latency 1 cycle. A `sound` sampled at edge N is visible after edge N.
- `quotient`: latency 1 cycle. The divide is combinational between the input and the output register.
- Throughput is 1 result per cycle per channel, with back-to-back changes supported.
- Reset (`reset_n` low) immediately forces `constant` = 0 and `quotient` = 0, independent of the clock.
- The first valid outputs appear at the first rising edge after `reset_n` deasserts. Asserting reset mid-stream discards the in-flight results.
- Simultaneous changes on both channels do not interact.

## Configuration
- `PITCHCONST_SAT_EN`
  - Defined: a `constant` overflow (v > 24'hFFFFFF) clamps to 24'hFFFFFF.
  - Undefined: `constant` = v[23:0] (wrap-around truncation). No clamp logic is built.
- The divider's denom = 0 behaviour is the same in both builds.

## Test plan
- Reset: hold `reset_n` = 0 while driving inputs → `constant` = 0 and `quotient` = 0. Release → outputs follow the inputs one cycle later.
- Octave map:
  - sound = 197 → 24'h258BF2.
  - sound = 209 → 24'h4B17E4.
  - sound = 185 → 24'h12C5F9.
  - Each result must appear exactly 1 cycle after the input.
- Saturation: sound = 511 → 24'hFFFFFF with `PITCHCONST_SAT_EN`, and the wrapped v[23:0] without it. Sweep sound 0..511 against a reference model of the T[k] formula; the result must be monotonic non-decreasing in the SAT build.
- Divider:
  - numer = 24'h258BF2, denom = 3 → 25'h0C83FB.
  - denom = 1 → quotient = numer.
  - numer = 24'hFFFFFF, denom = 255 → 25'h010101.
- Divide by zero: denom = 0, any numer → 25'h0FFFFFF. The next cycle with denom = 2, numer = 100 → 50.
- Streaming: random `sound`/`numer`/`denom` every cycle for 10k cycles with asynchronous reset pulses inserted mid-stream → outputs match the model delayed by 1 cycle, and are 0 during and immediately after each reset.

Source files
------------

// File: rtl/pitch_const_div_if.sv
// Purpose : bundles the two data channels of pitch_const_div (key->increment map, 24/8 divider).
// Latency : n/a (signal bundle only).
// Backpres: none; both channels sample every cycle with no handshake.
// Signals : sound[8:0] key index in, constant[23:0] increment out,
//           numer[23:0] dividend in, denom[7:0] divisor in, quotient[24:0] out.
interface pitch_const_div_if;
  logic [8:0]  sound;
  logic [23:0] constant;
  logic [23:0] numer;
  logic [7:0]  denom;
  logic [24:0] quotient;

  // master drives the operands, slave (the datapath) returns results
  modport master (output sound, numer, denom, input constant, quotient);
  modport slave  (input sound, numer, denom, output constant, quotient);
endinterface

// File: rtl/pitch_const_div.sv
// Purpose : key index -> 24-bit phase increment (12-entry semitone table, octave shift)
//           plus an independent unsigned 24/8 divider for modulator:carrier ratios.
// Latency : 1 cycle on both channels; backpressure: none, new operands accepted every cycle.
// Ports   : sCLK_XVXOSC clock (rising edge), reset_n async active-low (clears both outputs),
//           bus (pitch_const_div_if.slave) carries sound/constant and numer/denom/quotient.
// Build   : define PITCHCONST_SAT_EN to clamp increment overflow to 24'hFFFFFF;
//           otherwise the increment wraps to its low 24 bits.
module pitch_const_div #(
  parameter int unsigned REF_KEY = 197,
  parameter logic [23:0] REF_VAL = 24'h258BF2
) (
  input logic               sCLK_XVXOSC,
  input logic               reset_n,
  pitch_const_div_if.slave  bus
);

  // Semitone table entry k = round(REF_VAL * 2^(k/12) * 256); evaluated at elaboration only.
  // Entries 12..15 are never selected; they pad the table to a power-of-two index.
  function automatic logic [31:0] semi_entry(input int k);
    real r;
    if (k >= 12) return 32'd0;
    r = real'(REF_VAL) * 256.0 * (2.0 ** (real'(k) / 12.0));
    return 32'(longint'($floor(r + 0.5)));
  endfunction

  localparam logic [31:0] KTBL [16] = '{
    semi_entry(0),  semi_entry(1),  semi_entry(2),  semi_entry(3),
    semi_entry(4),  semi_entry(5),  semi_entry(6),  semi_entry(7),
    semi_entry(8),  semi_entry(9),  semi_entry(10), semi_entry(11),
    semi_entry(12), semi_entry(13), semi_entry(14), semi_entry(15)
  };

  logic signed [15:0] d;       // key offset from the reference key
  logic signed [15:0] o;       // octave = floor(d/12)
  logic signed [15:0] k;       // semitone within octave, 0..11
  logic signed [15:0] sh;      // net shift: table holds 8 fractional bits, so o-8
  logic signed [15:0] sh_n;    // right-shift amount when sh < 0
  logic [31:0]        t_sel;
  logic [23:0]        const_d, const_q;
  logic [24:0]        quot_d, quot_q;
`ifdef PITCHCONST_SAT_EN
  logic [63:0]        v_full;  // wide enough to expose every overflow bit of a <32 left shift
`endif

  always_comb begin
    d = $signed({7'd0, bus.sound}) - $signed(16'(REF_KEY));
    // SV division truncates toward zero; fold negative remainders to get a floor divide
    o = d / 16'sd12;
    k = d % 16'sd12;
    if (k < 16'sd0) begin
      k = k + 16'sd12;
      o = o - 16'sd1;
    end
    t_sel = KTBL[k[3:0]];
    sh    = o - 16'sd8;
    sh_n  = -sh;
`ifdef PITCHCONST_SAT_EN
    v_full = 64'd0;
    if (sh >= 16'sd32)
      v_full = '1;                               // beyond any representable shift: saturate
    else if (sh >= 16'sd0)
      v_full = {32'd0, t_sel} << sh;
    else
      v_full = {32'd0, t_sel} >> sh_n;           // amounts >= 32 drain to zero
    const_d = (|v_full[63:24]) ? 24'hFFFFFF : v_full[23:0];
`else
    if (sh >= 16'sd32)
      const_d = 24'hFFFFFF;
    else if (sh >= 16'sd0)
      const_d = 24'(t_sel << sh);                // keep only the low 24 bits (wrap)
    else
      const_d = 24'(t_sel >> sh_n);
`endif
    // divide by zero reports all-ones in the 24 quotient bits, bit 24 stays clear
    if (bus.denom == 8'd0)
      quot_d = 25'h0FFFFFF;
    else
      quot_d = {1'b0, bus.numer / {16'd0, bus.denom}};
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_n) begin
    if (!reset_n) begin
      const_q <= 24'd0;
      quot_q  <= 25'd0;
    end else begin
      const_q <= const_d;
      quot_q  <= quot_d;
    end
  end

  assign bus.constant = const_q;
  assign bus.quotient = quot_q;

endmodule

// File: tb/tb_pitch_const_div.sv
// Purpose : directed and streaming self-check of pitch_const_div (both build flavours).
// Latency : expects every result one clock after its operands.
// Backpres: none; operands change every cycle, async reset pulses injected mid-stream.
module tb_pitch_const_div;
  localparam int unsigned REF_KEY = 197;
  localparam logic [23:0] REF_VAL = 24'h258BF2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pitch_const_div_if bus();

  pitch_const_div #(.REF_KEY(REF_KEY), .REF_VAL(REF_VAL)) dut (
    .sCLK_XVXOSC(clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Reference: floor octave, rounded semitone constant, then exact multiply/divide by 2^(o-8).
  function automatic logic [23:0] m_const(input logic [8:0] s);
    int d, o, k;
    real r;
    logic [63:0] t, v;
    d = int'(s) - int'(REF_KEY);
    if (d >= 0) o = d / 12;
    else        o = -((-d + 11) / 12);
    k = d - 12 * o;
    r = real'(REF_VAL) * 256.0 * (2.0 ** (real'(k) / 12.0));
    t = longint'($floor(r + 0.5));
    if (o - 8 >= 32)     v = '1;
    else if (o >= 8)     v = t * (64'd1 << (o - 8));
    else if (8 - o < 32) v = t / (64'd1 << (8 - o));
    else                 v = 64'd0;
`ifdef PITCHCONST_SAT_EN
    if (v > 64'h0000_0000_00FF_FFFF) return 24'hFFFFFF;
`endif
    return v[23:0];
  endfunction

  function automatic logic [24:0] m_quot(input logic [23:0] n, input logic [7:0] dn);
    if (dn == 8'd0) return 25'h0FFFFFF;
    return {1'b0, n / {16'd0, dn}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] s, input logic [23:0] n, input logic [7:0] dn);
    bus.sound = s;
    bus.numer = n;
    bus.denom = dn;
  endtask

  initial begin
    logic [23:0] exp_c, prev_c;
    logic [24:0] exp_q;

    // reset held with live inputs: outputs stay zero, clocked or not
    drive(9'd197, 24'd123, 8'd4);
    #2;
    chk("rst_async_const", 32'(bus.constant), 32'h0);
    chk("rst_async_quot",  32'(bus.quotient), 32'h0);
    tick();
    chk("rst_clk_const", 32'(bus.constant), 32'h0);
    chk("rst_clk_quot",  32'(bus.quotient), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_pre_edge_const", 32'(bus.constant), 32'h0);
    tick();
    chk("first_const_197", 32'(bus.constant), 32'h258BF2);
    chk("first_quot_123_4", 32'(bus.quotient), 32'd30);

    // result must not move before the next edge
    drive(9'd209, 24'h258BF2, 8'd3);
    #1;
    chk("hold_before_edge", 32'(bus.constant), 32'h258BF2);
    tick();
    chk("const_209", 32'(bus.constant), 32'h4B17E4);
    chk("quot_ref_div3", 32'(bus.quotient), 32'h0C83FB);

    drive(9'd185, 24'hABCDEF, 8'd1);
    tick();
    chk("const_185", 32'(bus.constant), 32'h12C5F9);
    chk("quot_div1", 32'(bus.quotient), 32'hABCDEF);

    drive(9'd173, 24'hFFFFFF, 8'd255);
    tick();
    chk("const_173", 32'(bus.constant), 32'h0962FC);
    chk("quot_max_255", 32'(bus.quotient), 32'h010101);

    drive(9'd221, 24'd77, 8'd0);
    tick();
    chk("const_221", 32'(bus.constant), 32'h962FC8);
    chk("quot_div0", 32'(bus.quotient), 32'h0FFFFFF);

    drive(9'd233, 24'd100, 8'd2);
    tick();
`ifdef PITCHCONST_SAT_EN
    chk("const_233_sat", 32'(bus.constant), 32'hFFFFFF);
`else
    chk("const_233_wrap", 32'(bus.constant), 32'h2C5F90);
`endif
    chk("quot_after_div0", 32'(bus.quotient), 32'd50);

    drive(9'd305, 24'd0, 8'd0);
    tick();
`ifdef PITCHCONST_SAT_EN
    chk("const_305_sat", 32'(bus.constant), 32'hFFFFFF);
`else
    chk("const_305_wrap", 32'(bus.constant), 32'h17E400);
`endif
    chk("quot_zero_div0", 32'(bus.quotient), 32'h0FFFFFF);

    drive(9'd511, 24'd5, 8'd7);
    tick();
`ifdef PITCHCONST_SAT_EN
    chk("const_511_sat", 32'(bus.constant), 32'hFFFFFF);
`else
    chk("const_511_wrap", 32'(bus.constant), 32'(m_const(9'd511)));
`endif
    chk("quot_5_7", 32'(bus.quotient), 32'd0);

    // full key sweep against the formula model
    prev_c = 24'd0;
    for (int s = 0; s < 512; s++) begin
      bus.sound = 9'(s);
      tick();
      chk("sweep_const", 32'(bus.constant), 32'(m_const(9'(s))));
`ifdef PITCHCONST_SAT_EN
      chk("sweep_monotonic", 32'(bus.constant >= prev_c), 32'd1);
`endif
      prev_c = bus.constant;
    end

    // random streaming with async reset pulses
    for (int i = 0; i < 10000; i++) begin
      drive(9'($urandom_range(0, 511)), 24'($urandom), 8'($urandom_range(0, 255)));
      if (i % 97 == 0) bus.denom = 8'd0;
      exp_c = m_const(bus.sound);
      exp_q = m_quot(bus.numer, bus.denom);
      tick();
      chk("stream_const", 32'(bus.constant), 32'(exp_c));
      chk("stream_quot",  32'(bus.quotient), 32'(exp_q));
      if (i % 1500 == 750) begin
        #1 rst_n = 1'b0;
        #1;
        chk("stream_rst_const", 32'(bus.constant), 32'h0);
        chk("stream_rst_quot",  32'(bus.quotient), 32'h0);
        tick();
        chk("stream_rst_hold", 32'({bus.constant, bus.quotient}), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("stream_post_rel_const", 32'(bus.constant), 32'h0);
        chk("stream_post_rel_quot",  32'(bus.quotient), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
